am25ls2548_ctl: RTL and testbench
=================================

Name: am25ls2548_ctl

Overview:
- Bus-cycle sequencer and round-robin arbiter for the eight-output decoder/demultiplexer with storage (3-bit select, active-low enable, rd_/wr_ strobes, ack_ return).
- Four requesters share one decoder. The block arbitrates between them, drives select and enable, and times the read/write strobe.
- It checks the decoder's ack_ and returns a per-requester done pulse plus an error flag.
- Sits between local control sequencers and the peripheral-select decoder.

Parameters:
WS, 2, strobe width in clock cycles (legal 1..15; 0 is treated as 1)

Ports:
clk      input   1   system clock, all state changes on rising edge
rst_     input   1   asynchronous active-low reset
req_     input   4   per-requester cycle request, active low, level
radr     input   12  per-requester select address, 3 bits each: requester i uses radr[3i+2:3i]
rwr      input   4   per-requester direction, 1=write, 0=read
gnt_     output  4   per-requester grant, active low, one-hot or all high
done     output  4   per-requester completion pulse, active high, 1 cycle
err      output  1   ack missing, 1-cycle pulse coincident with done
busy     output  1   high in any state other than IDLE
a        output  1   decoder select bit 0
b        output  1   decoder select bit 1
c        output  1   decoder select bit 2
e1_      output  1   decoder enable, active low (other decoder enables tied active externally)
rd_      output  1   read strobe, active low
wr_      output  1   write strobe, active low
ack_     input   1   acknowledge from decoder, active low

Behaviour:
- Clock and reset: one clock, clk. Reset rst_ is asynchronous and active-low. All outputs are registered.
- Reset values:
  - state=IDLE; last-granted pointer=3, so requester 0 wins first.
  - a=b=c=0, e1_=1, rd_=wr_=1.
  - gnt_=4'b1111, done=0, err=0, busy=0, strobe counter=0.
- Reset asserted mid-cycle aborts immediately to the reset values. No done or err is produced for the aborted cycle.
- IDLE:
  - If any req_ bit is low, choose the first low bit searching from (last+1) mod 4 upward with wrap.
  - Latch the winner's index, its 3-bit radr slice and its rwr bit. Update last to the winner. Next state SETUP.
  - If no request, stay in IDLE.
- SETUP (1 cycle):
  - gnt_[winner]=0.
  - {c,b,a}=latched address, e1_=0, rd_=wr_=1.
  - Load the strobe counter with WS (or 1 if WS=0). Next state STROBE.
- STROBE (WS cycles):
  - Address, enable and grant held.
  - If latched rwr=1: wr_=0, rd_=1. Else rd_=0, wr_=1.
  - The counter decrements each cycle. On the cycle the counter equals 1, sample ack_ into an internal flag (1 = missing). Next state HOLD.
- HOLD (1 cycle):
  - rd_=wr_=1. Address, e1_ and gnt_ are still held, giving a strobe-trailing hold time.
  - done[winner]=1 for exactly this cycle. err=flag for exactly this cycle.
  - Next state IDLE. On entry to IDLE: e1_=1, gnt_=4'b1111, {c,b,a} keep their last value.
- Timing: from the IDLE cycle that accepts a request, SETUP+STROBE+HOLD occupies WS+2 cycles, and the next grant can occur WS+3 cycles after acceptance.
- Back-to-back cycles: a requester that holds req_ low re-arbitrates in IDLE. Round-robin guarantees every other pending requester is served before it repeats. Maximum wait for any requester is 3 full cycles.
- Request changes:
  - req_, radr and rwr changing after acceptance are ignored; the latched values are used.
  - A req_ released after acceptance does not cancel the cycle.
- Invariants:
  - rd_ and wr_ are never low simultaneously.
  - A strobe is never low while e1_ is high.
  - At most one gnt_ bit is low.
- err does not block the FSM; the cycle completes normally.

Test Plan:
- Reset: rst_ low -> all outputs at reset values. Release, no requests -> stays IDLE, busy=0.
- Single read, WS=2: req_=4'b1110, radr[2:0]=3'b101, rwr[0]=0, ack_ driven low while strobe low.
  - Cycle+1: gnt_=1110, e1_=0, {c,b,a}=101.
  - Cycles +2/+3: rd_=0, wr_=1.
  - Cycle+4: done=0001, err=0.
  - Cycle+5: IDLE, e1_=1.
- Write with missing ack, WS=3: requester 2, radr[8:6]=3'b011, rwr[2]=1, ack_ held high -> wr_ low 3 cycles, then done=0100 with err=1 in the same cycle.
- Round-robin: req_=4'b0000 held continuously -> grant order 0,1,2,3,0, each cycle WS+3 clocks apart. Never two gnt_ bits low at once.
- Reset mid-strobe: assert rst_ during STROBE -> rd_/wr_/e1_ high and gnt_=1111 asynchronously, no done pulse. After release, requester 0 is granted first.
- WS=0 edge: single write -> strobe low exactly 1 cycle, done 3 cycles after acceptance.

Source files
------------

// File: rtl/am25ls2548_ctl_if.sv
// Requester/decoder bus of the Am25LS2548 cycle sequencer.
// master: the sequencer; slave: requesters plus the decoder.
interface am25ls2548_ctl_if;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ADR_W = 3;

  logic [N_REQ-1:0]       req_;
  logic [N_REQ*ADR_W-1:0] radr;
  logic [N_REQ-1:0]       rwr;
  logic [N_REQ-1:0]       gnt_;
  logic [N_REQ-1:0]       done;
  logic                   err;
  logic                   busy;
  logic                   a;
  logic                   b;
  logic                   c;
  logic                   e1_;
  logic                   rd_;
  logic                   wr_;
  logic                   ack_;

  modport master (
    input  req_, radr, rwr, ack_,
    output gnt_, done, err, busy, a, b, c, e1_, rd_, wr_
  );

  modport slave (
    output req_, radr, rwr, ack_,
    input  gnt_, done, err, busy, a, b, c, e1_, rd_, wr_
  );
endinterface

// File: rtl/am25ls2548_ctl.sv
// Round-robin arbiter and bus-cycle sequencer for four requesters sharing
// one Am25LS2548 decoder: select/enable setup, timed strobe, hold, done/err.
module am25ls2548_ctl #(
  parameter int unsigned WS = 2
) (
  input  logic                    clk,
  input  logic                    rst_,
  am25ls2548_ctl_if.master        bus
);
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ADR_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WS_EFF = (WS == 0) ? 1 : WS;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] win;
  logic             wr_lat;
  logic [CNT_W-1:0] cnt;

  logic             found_c;
  logic [IDX_W-1:0] pick_c;
  logic [ADR_W-1:0] adr_c;

  // First pending request searching upward from the one after the last winner.
  always_comb begin
    found_c = 1'b0;
    pick_c  = last;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      if (!found_c && !bus.req_[last + IDX_W'(i)]) begin
        found_c = 1'b1;
        pick_c  = last + IDX_W'(i);
      end
    end
    adr_c = bus.radr[ADR_W*pick_c +: ADR_W];
  end

  // Sequencer; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state                     <= IDLE;
      last                      <= IDX_W'(N_REQ - 1);
      win                       <= '0;
      wr_lat                    <= 1'b0;
      cnt                       <= '0;
      bus.gnt_                  <= '1;
      bus.done                  <= '0;
      bus.err                   <= 1'b0;
      bus.busy                  <= 1'b0;
      {bus.c, bus.b, bus.a}     <= '0;
      bus.e1_                   <= 1'b1;
      bus.rd_                   <= 1'b1;
      bus.wr_                   <= 1'b1;
    end else begin
      bus.done <= '0;
      bus.err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found_c) begin
            state                 <= SETUP;
            win                   <= pick_c;
            last                  <= pick_c;
            wr_lat                <= bus.rwr[pick_c];
            bus.gnt_              <= ~(N_REQ'(1) << pick_c);
            {bus.c, bus.b, bus.a} <= adr_c;
            bus.e1_               <= 1'b0;
            bus.busy              <= 1'b1;
          end
        end
        SETUP: begin
          state   <= STROBE;
          cnt     <= CNT_W'(WS_EFF);
          bus.wr_ <= !wr_lat;
          bus.rd_ <= wr_lat;
        end
        STROBE: begin
          cnt <= cnt - CNT_W'(1);
          // Last strobe cycle: ack_ high here means the decoder never answered.
          if (cnt == CNT_W'(1)) begin
            state          <= HOLD;
            bus.rd_        <= 1'b1;
            bus.wr_        <= 1'b1;
            bus.done[win]  <= 1'b1;
            bus.err        <= bus.ack_;
          end
        end
        HOLD: begin
          state    <= IDLE;
          bus.e1_  <= 1'b1;
          bus.gnt_ <= '1;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_am25ls2548_ctl.sv
// Bench for am25ls2548_ctl: three instances (WS=2,3,0), each checked every
// cycle against a transaction-timeline model, plus directed literal checks.
module tb_am25ls2548_ctl;
  logic clk = 1'b0;
  logic rst_;
  logic [3:0]  req_v  [3];
  logic [11:0] radr_v [3];
  logic [3:0]  rwr_v  [3];
  logic        ack_on [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS_P = (g == 0) ? 2 : (g == 1) ? 3 : 0;
    localparam int unsigned WSE  = (WS_P == 0) ? 1 : WS_P;

    am25ls2548_ctl_if bus();
    assign bus.req_ = req_v[g];
    assign bus.radr = radr_v[g];
    assign bus.rwr  = rwr_v[g];
    assign bus.ack_ = ack_on[g] ? (bus.rd_ & bus.wr_) : 1'b1;

    am25ls2548_ctl #(.WS(WS_P)) dut (.clk(clk), .rst_(rst_), .bus(bus));

    // Model: a transaction is an acceptance edge plus the count of edges since.
    bit          act = 1'b0;
    int unsigned d = 0;
    int unsigned last = 3;
    int unsigned w = 0;
    logic [3:0]  oh = 4'b0001;
    logic [2:0]  adr = 3'b000;
    bit          wrm = 1'b0;
    bit          flag = 1'b0;
    bit          picked;

    always @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        act = 1'b0; d = 0; last = 3; w = 0; oh = 4'b0001;
        adr = 3'b000; wrm = 1'b0; flag = 1'b0;
      end else if (act) begin
        d++;
        if (d == WSE + 1) flag = bus.ack_;
        if (d == WSE + 2) act = 1'b0;
      end else begin
        picked = 1'b0;
        for (int i = 1; i <= 4; i++) begin
          if (!picked && !req_v[g][(last + i) % 4]) begin
            picked = 1'b1;
            w      = (last + i) % 4;
          end
        end
        if (picked) begin
          act  = 1'b1;
          d    = 0;
          last = w;
          oh   = 4'b0001 << w;
          adr  = radr_v[g][3*w +: 3];
          wrm  = rwr_v[g][w];
        end
      end
    end

    logic [3:0] gnt_e, done_e;
    logic       stb, rd_e, wr_e, err_e;

    always @(negedge clk) begin
      stb    = act && (d >= 1) && (d <= WSE);
      gnt_e  = act ? ~oh : 4'hF;
      done_e = (act && d == WSE + 1) ? oh : 4'h0;
      err_e  = act && (d == WSE + 1) && flag;
      rd_e   = !(stb && !wrm);
      wr_e   = !(stb && wrm);
      chk($sformatf("i%0d gnt_", g), bus.gnt_, gnt_e);
      chk($sformatf("i%0d done", g), bus.done, done_e);
      chk($sformatf("i%0d err", g), bus.err, err_e);
      chk($sformatf("i%0d busy", g), bus.busy, act);
      chk($sformatf("i%0d e1_", g), bus.e1_, !act);
      chk($sformatf("i%0d rd_", g), bus.rd_, rd_e);
      chk($sformatf("i%0d wr_", g), bus.wr_, wr_e);
      chk($sformatf("i%0d cba", g), {bus.c, bus.b, bus.a}, adr);
      chk($sformatf("i%0d inv rd_wr", g), (!bus.rd_ && !bus.wr_), 1'b0);
      chk($sformatf("i%0d inv stb_e1", g), ((!bus.rd_ || !bus.wr_) && bus.e1_), 1'b0);
      chk($sformatf("i%0d inv gnt1hot", g), $onehot0(~bus.gnt_), 1'b1);
    end
  end

  int gidx [8];
  int gcyc [8];
  int ng;
  logic [3:0] prev, cur;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 4'hF; radr_v[i] = '0; rwr_v[i] = '0; ack_on[i] = 1'b1;
    end

    // Reset values, then idle with no requests
    tick(3);
    chk("rst gnt_", g_dut[0].bus.gnt_, 4'hF);
    chk("rst e1_", g_dut[0].bus.e1_, 1'b1);
    chk("rst rd_wr", {g_dut[0].bus.rd_, g_dut[0].bus.wr_}, 2'b11);
    chk("rst cba", {g_dut[0].bus.c, g_dut[0].bus.b, g_dut[0].bus.a}, 3'b000);
    chk("rst busy", g_dut[0].bus.busy, 1'b0);
    rst_ = 1'b1;
    tick(3);
    chk("idle busy", g_dut[0].bus.busy, 1'b0);

    // Single read on instance 0 (WS=2), requester 0, address 101
    req_v[0] = 4'b1110; radr_v[0] = 12'h005; rwr_v[0] = 4'b0000;
    tick(1);
    chk("rd setup gnt_", g_dut[0].bus.gnt_, 4'b1110);
    chk("rd setup e1_", g_dut[0].bus.e1_, 1'b0);
    chk("rd setup cba", {g_dut[0].bus.c, g_dut[0].bus.b, g_dut[0].bus.a}, 3'b101);
    req_v[0] = 4'hF; radr_v[0] = 12'h002;
    tick(1);
    chk("rd stb1", {g_dut[0].bus.rd_, g_dut[0].bus.wr_}, 2'b01);
    tick(1);
    chk("rd stb2", {g_dut[0].bus.rd_, g_dut[0].bus.wr_}, 2'b01);
    tick(1);
    chk("rd done", g_dut[0].bus.done, 4'b0001);
    chk("rd err", g_dut[0].bus.err, 1'b0);
    tick(1);
    chk("rd idle e1_", g_dut[0].bus.e1_, 1'b1);
    chk("rd idle cba", {g_dut[0].bus.c, g_dut[0].bus.b, g_dut[0].bus.a}, 3'b101);

    // Write with missing ack on instance 1 (WS=3), requester 2, address 011
    req_v[1] = 4'b1011; radr_v[1] = 12'h0C0; rwr_v[1] = 4'b0100; ack_on[1] = 1'b0;
    tick(1);
    chk("wr setup gnt_", g_dut[1].bus.gnt_, 4'b1011);
    chk("wr setup cba", {g_dut[1].bus.c, g_dut[1].bus.b, g_dut[1].bus.a}, 3'b011);
    req_v[1] = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("wr stb", {g_dut[1].bus.rd_, g_dut[1].bus.wr_}, 2'b10);
    end
    tick(1);
    chk("wr done", g_dut[1].bus.done, 4'b0100);
    chk("wr err", g_dut[1].bus.err, 1'b1);
    tick(2);

    // Reset during a strobe on instance 0, requester 3
    req_v[0] = 4'b0111; radr_v[0] = 12'hE00; rwr_v[0] = 4'b0000;
    tick(1);
    chk("mid setup gnt_", g_dut[0].bus.gnt_, 4'b0111);
    tick(1);
    chk("mid stb rd_", g_dut[0].bus.rd_, 1'b0);
    #2 rst_ = 1'b0;
    #1;
    chk("mid async rd_", g_dut[0].bus.rd_, 1'b1);
    chk("mid async e1_", g_dut[0].bus.e1_, 1'b1);
    chk("mid async gnt_", g_dut[0].bus.gnt_, 4'hF);
    req_v[0] = 4'hF;
    tick(1);
    chk("mid no done", g_dut[0].bus.done, 4'h0);
    rst_ = 1'b1;
    tick(1);

    // Round robin with all four requesting continuously
    req_v[0] = 4'b0000; radr_v[0] = {3'd6, 3'd3, 3'd4, 3'd1}; rwr_v[0] = 4'b1010;
    ng = 0; prev = 4'hF;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      tick(1);
      cur = g_dut[0].bus.gnt_;
      if (cur != 4'hF && prev == 4'hF && ng < 8) begin
        gidx[ng] = 0;
        for (int i = 0; i < 4; i++) if (!cur[i]) gidx[ng] = i;
        gcyc[ng] = cyc;
        ng++;
      end
      prev = cur;
    end
    req_v[0] = 4'hF;
    chk("rr grant count", ng, 5);
    for (int k = 0; k < 5 && k < ng; k++) begin
      chk($sformatf("rr order %0d", k), gidx[k], exp_order[k]);
      if (k > 0) chk($sformatf("rr spacing %0d", k), gcyc[k] - gcyc[k-1], 5);
    end
    tick(6);

    // WS=0 on instance 2: single write, requester 1, address 110
    req_v[2] = 4'b1101; radr_v[2] = 12'h030; rwr_v[2] = 4'b0010;
    tick(1);
    chk("ws0 setup gnt_", g_dut[2].bus.gnt_, 4'b1101);
    chk("ws0 setup cba", {g_dut[2].bus.c, g_dut[2].bus.b, g_dut[2].bus.a}, 3'b110);
    req_v[2] = 4'hF;
    tick(1);
    chk("ws0 stb", {g_dut[2].bus.rd_, g_dut[2].bus.wr_}, 2'b10);
    tick(1);
    chk("ws0 done", g_dut[2].bus.done, 4'b0010);
    chk("ws0 stb end", g_dut[2].bus.wr_, 1'b1);
    chk("ws0 err", g_dut[2].bus.err, 1'b0);
    tick(1);
    chk("ws0 idle gnt_", g_dut[2].bus.gnt_, 4'hF);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
